// File: rtl/column_step_sync_pkg.sv
// column_step_sync_pkg: shared widths, fixed-point format, FSM encodings and audio full-scale constants
package column_step_sync_pkg;

    localparam int DATA_W     = 18;
    localparam int FRAC_W     = 17;
    localparam int AUDIO_W    = 32;
    localparam int GAIN_SHIFT = 2;
    localparam int PAD_W      = AUDIO_W - DATA_W;

    localparam logic [AUDIO_W-1:0] AUDIO_MAX = 32'h7FFF_FFFF;
    localparam logic [AUDIO_W-1:0] AUDIO_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        WAIT_DONE = 2'd0,
        CAPTURE   = 2'd1,
        PUSH      = 2'd2,
        START     = 2'd3
    } state_t;

endpackage

// File: rtl/column_step_sync_if.sv
// column_step_sync_if: column completion inputs, drive-column sample and audio FIFO handshake
interface column_step_sync_if
    import column_step_sync_pkg::*;
#(
    parameter int NUM_COLS = 30
);

    logic [NUM_COLS-1:0]      col_done;
    logic signed [DATA_W-1:0] u_mid;
    logic                     audio_ready;
    logic [AUDIO_W-1:0]       audio_data;
    logic                     audio_valid;
    logic                     start;
    logic [31:0]              step_count;
    logic                     busy;

    modport master (
        output col_done, u_mid, audio_ready,
        input  audio_data, audio_valid, start, step_count, busy
    );

    modport slave (
        input  col_done, u_mid, audio_ready,
        output audio_data, audio_valid, start, step_count, busy
    );

endinterface

// File: rtl/column_step_sync_audio_fmt.sv
// column_step_sync_audio_fmt: left-justify a 1.17 sample into the audio word; AUDIO_GAIN_EN adds gain with saturation
module column_step_sync_audio_fmt
    import column_step_sync_pkg::*;
(
    input  logic signed [DATA_W-1:0] sample,
    output logic [AUDIO_W-1:0]       audio
);

`ifdef AUDIO_GAIN_EN
    logic [DATA_W+GAIN_SHIFT-1:0] shifted;
    logic                         ovf;

    // shift in a widened word, saturate if the bits above the new sign disagree with it
    always_comb begin
        shifted = {{GAIN_SHIFT{sample[DATA_W-1]}}, sample} << GAIN_SHIFT;
        ovf     = shifted[DATA_W+GAIN_SHIFT-1:DATA_W-1] != {(GAIN_SHIFT+1){shifted[DATA_W-1]}};
        audio   = ovf ? (sample[DATA_W-1] ? AUDIO_MIN : AUDIO_MAX)
                      : {shifted[DATA_W-1:0], {PAD_W{1'b0}}};
    end
`else
    assign audio = {sample, {PAD_W{1'b0}}};
`endif

endmodule

// File: rtl/column_step_sync.sv
// column_step_sync: gathers column done edges, pushes the drive-column sample to audio, launches the next step
module column_step_sync
    import column_step_sync_pkg::*;
#(
    parameter int NUM_COLS = 30
)(
    input logic               clk,
    input logic               reset,
    column_step_sync_if.slave bus
);

    state_t                   state, state_next;
    logic [NUM_COLS-1:0]      col_prev, done_mask, rise, mask_or;
    logic signed [DATA_W-1:0] sample;

    assign rise    = bus.col_done & ~col_prev;
    assign mask_or = done_mask | rise;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_DONE;
        else       state <= state_next;
    end

    // next state: the mask check already includes this cycle's edges
    always_comb begin
        state_next = state;
        case (state)
            WAIT_DONE: state_next = &mask_or ? CAPTURE : WAIT_DONE;
            CAPTURE:   state_next = PUSH;
            PUSH:      state_next = (bus.audio_valid && bus.audio_ready) ? START : PUSH;
            START:     state_next = WAIT_DONE;
        endcase
    end

    // decoded outputs
    always_comb begin
        bus.start = state == START;
        bus.busy  = state != WAIT_DONE;
    end

    // edge detect, done mask, sample latch, audio valid and step counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_prev        <= '0;
            done_mask       <= '0;
            sample          <= '0;
            bus.audio_valid <= 1'b0;
            bus.step_count  <= '0;
        end else begin
            col_prev <= bus.col_done;
            if (state == START) done_mask <= '0;
            else if (state == WAIT_DONE) done_mask <= mask_or;
            if (state == CAPTURE) begin
                sample          <= bus.u_mid;
                bus.audio_valid <= 1'b1;
            end else if (state == PUSH && bus.audio_ready) begin
                bus.audio_valid <= 1'b0;
            end
            if (state == START) bus.step_count <= bus.step_count + 32'd1;
        end
    end

    column_step_sync_audio_fmt u_fmt (
        .sample (sample),
        .audio  (bus.audio_data)
    );

endmodule

// File: tb/tb_column_step_sync.sv
// tb_column_step_sync: table-driven steps with an audio scoreboard plus hand-written latency, backpressure and reset sequences
module tb_column_step_sync;
    import column_step_sync_pkg::*;

    localparam int NC = 4;
`ifdef AUDIO_GAIN_EN
    localparam bit GAIN = 1'b1;
`else
    localparam bit GAIN = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0]  u;
        int                 dly;
        logic [AUDIO_W-1:0] e_plain;
        logic [AUDIO_W-1:0] e_gain;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   starts = 0;
    logic [AUDIO_W-1:0] sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    column_step_sync_if #(.NUM_COLS(NC)) bus();

    column_step_sync #(.NUM_COLS(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!bus.audio_valid && k < 10) begin
            cyc(1);
            k++;
        end
        check({name, "_valid"}, 32'(bus.audio_valid), 32'd1);
    endtask

    task automatic wait_start(input string name);
        int k = 0;
        while (!bus.start && k < 20) begin
            cyc(1);
            k++;
        end
        check({name, "_start"}, 32'(bus.start), 32'd1);
    endtask

    function automatic logic [31:0] pick(input logic [31:0] plain, input logic [31:0] gain);
        return GAIN ? gain : plain;
    endfunction

    task automatic run_step(input logic [DATA_W-1:0] u, input int dly, input logic [31:0] exp, input string name);
        int bad = 0;
        bus.u_mid = u;
        bus.audio_ready = 1'b0;
        bus.col_done = '0;
        cyc(1);
        bus.col_done = '1;
        sb.push_back(exp);
        wait_valid(name);
        for (int i = 0; i < dly; i++) begin
            if (bus.audio_data !== exp || !bus.audio_valid || bus.start) bad++;
            cyc(1);
        end
        check({name, "_hold"}, bad, 0);
        bus.audio_ready = 1'b1;
        wait_start(name);
        cyc(1);
        bus.audio_ready = 1'b0;
    endtask

    // audio scoreboard: every accepted word must match the oldest expectation
    always @(negedge clk) begin
        #1;
        if (!reset && bus.audio_valid && bus.audio_ready) begin
            if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
            else check("audio_word", bus.audio_data, sb.pop_front());
        end
        if (!reset && bus.start) starts++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int exp_steps;
        vecs[0] = '{18'h1FFFF, 0, 32'h7FFFC000, 32'h7FFFFFFF};
        vecs[1] = '{18'h20000, 3, 32'h80000000, 32'h80000000};
        vecs[2] = '{18'h0C000, 1, 32'h30000000, 32'h7FFFFFFF};
        vecs[3] = '{18'h00000, 0, 32'h00000000, 32'h00000000};
        vecs[4] = '{18'h3FFFF, 2, 32'hFFFFC000, 32'hFFFF0000};
        vecs[5] = '{18'h01000, 5, 32'h04000000, 32'h10000000};
        vecs[6] = '{18'h38000, 0, 32'hE0000000, 32'h80000000};
        vecs[7] = '{18'h30000, 1, 32'hC0000000, 32'h80000000};

        bus.col_done = '0;
        bus.u_mid = '0;
        bus.audio_ready = 1'b0;
        cyc(2);
        check("rst_valid", 32'(bus.audio_valid), 32'd0);
        check("rst_start", 32'(bus.start), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_steps", bus.step_count, 32'd0);
        check("rst_data", bus.audio_data, 32'd0);
        reset = 1'b0;

        bus.u_mid = 18'h1FFFF;
        bad = 0;
        for (int c = 1; c <= 9; c++) begin
            cyc(1);
            if (bus.start || bus.audio_valid || bus.busy) bad++;
            if (c % 2 == 1 && c >= 3) bus.col_done[(c - 3) / 2] = 1'b1;
        end
        sb.push_back(pick(32'h7FFFC000, 32'h7FFFFFFF));
        check("gather_idle", bad, 0);
        cyc(1);
        check("lat_edge1_valid", 32'(bus.audio_valid), 32'd0);
        check("lat_edge1_start", 32'(bus.start), 32'd0);
        cyc(1);
        check("lat_edge2_valid", 32'(bus.audio_valid), 32'd1);
        check("maxpos_data", bus.audio_data, pick(32'h7FFFC000, 32'h7FFFFFFF));
        bus.audio_ready = 1'b1;
        wait_start("maxpos");
        cyc(1);
        bus.audio_ready = 1'b0;
        check("maxpos_steps", bus.step_count, 32'd1);
        check("maxpos_start_low", 32'(bus.start), 32'd0);

        cyc(10);
        check("held_busy", 32'(bus.busy), 32'd0);
        check("held_valid", 32'(bus.audio_valid), 32'd0);
        check("held_starts", starts, 1);
        check("held_steps", bus.step_count, 32'd1);

        bus.u_mid = 18'h20000;
        bus.col_done = '0;
        cyc(1);
        bus.col_done = '1;
        sb.push_back(32'h80000000);
        wait_valid("maxneg");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.audio_data !== 32'h80000000 || !bus.audio_valid || bus.start) bad++;
            if (i == 4) bus.col_done = '0;
            if (i == 5) bus.col_done = '1;
            cyc(1);
        end
        check("maxneg_hold", bad, 0);
        check("maxneg_no_start", starts, 1);
        bus.audio_ready = 1'b1;
        wait_start("maxneg");
        cyc(1);
        bus.audio_ready = 1'b0;
        check("maxneg_steps", bus.step_count, 32'd2);
        cyc(8);
        check("discard_busy", 32'(bus.busy), 32'd0);
        check("discard_starts", starts, 2);

        bus.u_mid = 18'h01000;
        bus.col_done = '0;
        cyc(1);
        bus.col_done = '1;
        sb.push_back(pick(32'h04000000, 32'h10000000));
        wait_valid("prio");
        bus.col_done = '0;
        bus.audio_ready = 1'b1;
        cyc(1);
        check("prio_start", 32'(bus.start), 32'd1);
        bus.col_done = '1;
        bus.audio_ready = 1'b0;
        cyc(8);
        check("prio_busy", 32'(bus.busy), 32'd0);
        check("prio_steps", bus.step_count, 32'd3);

        exp_steps = 3;
        for (int v = 0; v < 8; v++) begin
            run_step(vecs[v].u, vecs[v].dly, pick(vecs[v].e_plain, vecs[v].e_gain), $sformatf("vec%0d", v));
            exp_steps++;
            check($sformatf("vec%0d_steps", v), bus.step_count, 32'(exp_steps));
        end
        check("vec_starts", starts, exp_steps);

        bus.u_mid = 18'h0C000;
        bus.col_done = '0;
        cyc(1);
        bus.col_done = '1;
        wait_valid("rstpush");
        cyc(2);
        reset = 1'b1;
        #1;
        check("rstpush_valid", 32'(bus.audio_valid), 32'd0);
        check("rstpush_busy", 32'(bus.busy), 32'd0);
        check("rstpush_steps", bus.step_count, 32'd0);
        bus.col_done = '0;
        cyc(2);
        reset = 1'b0;
        cyc(5);
        check("rstpush_idle", 32'(bus.busy), 32'd0);
        run_step(18'h0C000, 1, pick(32'h30000000, 32'h7FFFFFFF), "recover");
        check("recover_steps", bus.step_count, 32'd1);

        cyc(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
